hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage scalar+vector AES pipeline.
//  Tracks in-flight writers (EX, MEM, WB) of both register files in a shift scoreboard.
//  Generates load-use stalls, multi-cycle branch flush, EX-stage forward selects and
//  saturating stall/flush performance counters.
// PARAMETERS
//  REG_AW        5   register address width (scalar and vector files share address space)
//  FLUSH_CYCLES  1   IF/ID flush length after a taken branch (>=1)
//  ZERO_REG      1   1: scalar reg 0 is hard-wired, never a hazard nor forwarded
//  CNT_W         16  width of performance counters (saturating)
// PORTS
//  clk            in   1       pipeline clock, rising edge
//  rst            in   1       asynchronous reset, active-low
//  id_rs1         in   REG_AW  ID-stage source 1
//  id_rs2         in   REG_AW  ID-stage source 2
//  id_rd          in   REG_AW  ID-stage destination
//  id_reg_write   in   1       ID instr writes scalar file
//  id_vreg_write  in   1       ID instr writes vector file
//  id_vec_src     in   1       ID sources read vector file (else scalar)
//  id_is_load     in   1       ID instr result comes from memory (MemToReg load)
//  branch_taken   in   1       branch resolved taken in ID this cycle
//  pc_write       out  1       PC update enable
//  if_id_write    out  1       IF/ID register enable
//  if_id_flush    out  1       clear IF/ID to NOP
//  id_ex_bubble   out  1       force ID/EX control bits (MemWrite,RegWrite,VRegWrite) to 0
//  fw_a_sel       out  2       EX operand A: 00 regfile, 01 MEM ALUResult, 10 MEM MemData, 11 WB data
//  fw_b_sel       out  2       EX operand B: same encoding
//  stall_count    out  CNT_W   cycles with load-use stall
//  flush_count    out  CNT_W   cycles with if_id_flush high
// BEHAVIOUR
//  Scoreboard: 3 entries EX/MEM/WB, each {valid, rd, vec, load, rs1, rs2, vsrc}; shifts every
//   clk (EX->MEM->WB, WB discarded). EX entry loads ID fields; valid=reg_write|vreg_write,
//   vec=vreg_write. On id_ex_bubble, EX entry loads valid=0.
//  Match(entry,rs,vsrc): entry.valid & entry.rd==rs & entry.vec==vsrc &
//   ~(ZERO_REG & ~vsrc & rs==0).
//  Load-use stall (combinational): EX.load & (Match(EX,id_rs1) | Match(EX,id_rs2)) ->
//   pc_write=0, if_id_write=0, id_ex_bubble=1. Exactly 1 cycle per dependent load.
//  Forwarding (combinational, EX entry's rs1/rs2/vsrc): Match(MEM) -> MEM.load?10:01;
//   else Match(WB) -> 11; else 00. MEM has priority over WB.
//  Flush FSM: IDLE/FLUSH, counter fcnt. IDLE & branch_taken & ~stall ->
//   if_id_flush=1 same cycle, id_ex_bubble=0; if FLUSH_CYCLES>1 go FLUSH with
//   fcnt=FLUSH_CYCLES-1. FLUSH: if_id_flush=1, fcnt--, return IDLE at fcnt==1.
//   branch_taken while in FLUSH is ignored.
//  Stall and branch same cycle: stall wins, branch re-evaluated next cycle (ID held).
//  Counters: +1 per qualifying cycle, saturate at 2^CNT_W-1, no wrap.
//  Reset (rst=0, async, any time incl. mid-flush): scoreboard invalid, FSM IDLE,
//   fcnt=0, counters=0. Outputs: pc_write=1, if_id_write=1, if_id_flush=0,
//   id_ex_bubble=0, fw_*_sel=00.
// TESTING
//  ADD r3 then ADD r4,r3,r3 -> fw_a_sel=fw_b_sel=01 next cycle, stall_count=0.
//  LOAD r5 then ADD r6,r5,r1 -> 1-cycle stall (pc_write=0, bubble=1), then fw_a_sel=10,
//   stall_count=1.
//  Write r2, two unrelated instrs, read r2 -> fw 00 (no match). Gap of 1 -> fw 11.
//  Vector write v3 then scalar read r3 -> no forward/stall. Scalar write r0 -> never fw.
//  FLUSH_CYCLES=3, branch_taken 1 cycle -> if_id_flush high 3 cycles, flush_count=3.
//   Second branch_taken inside window ignored.
//  Assert rst=0 mid-flush -> all outputs reset values immediately. CNT_W=2 with 5
//   stalls -> stall_count=3.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Handshake bundle between the ID stage and the hazard scoreboard.
// The master drives the decoded ID-stage fields; the slave returns pipeline
// control, forward selects and the performance counters.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_vreg_write;
  logic              id_vec_src;
  logic              id_is_load;
  logic              branch_taken;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [1:0]        fw_a_sel;
  logic [1:0]        fw_b_sel;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_rs1, id_rs2, id_rd, id_reg_write, id_vreg_write, id_vec_src,
           id_is_load, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fw_a_sel,
           fw_b_sel, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd, id_reg_write, id_vreg_write, id_vec_src,
           id_is_load, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, fw_a_sel,
           fw_b_sel, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the 5-stage scalar+vector pipeline.
// Tracks in-flight writers in EX/MEM/WB, raises load-use stalls, drives
// branch flushes and EX forward selects, and counts stall/flush cycles.
//
// state   | meaning
// S_IDLE  | no flush in progress; a taken branch flushes IF/ID this cycle
// S_FLUSH | extra flush cycles after a branch; fcnt_q counts down to 1
module hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int ZERO_REG     = 1,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);
  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // WB and MEM only need what a consumer compares against; EX also keeps
  // its own sources because forwarding is resolved for the EX operands.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              vec;
    logic              load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              vsrc;
  } ex_entry_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              vec;
    logic              load;
  } mem_entry_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              vec;
  } wb_entry_t;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  ex_entry_t         ex_q;
  mem_entry_t        mem_q;
  wb_entry_t         wb_q;
  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              stall;
  logic              flush;

  // Scalar r0 reads a constant, so it can never depend on an in-flight writer.
  function automatic logic match(input logic valid, input logic [REG_AW-1:0] rd,
                                 input logic vec, input logic [REG_AW-1:0] rs,
                                 input logic vsrc);
    logic hardwired;
    hardwired = (ZERO_REG != 0) && !vsrc && (rs == '0);
    return valid && (rd == rs) && (vec == vsrc) && !hardwired;
  endfunction

  assign stall = ex_q.load &
                 (match(ex_q.valid, ex_q.rd, ex_q.vec, hz.id_rs1, hz.id_vec_src) |
                  match(ex_q.valid, ex_q.rd, ex_q.vec, hz.id_rs2, hz.id_vec_src));

  // Load-use stall holds PC and IF/ID and injects a bubble into EX.
  always_comb begin
    hz.pc_write     = ~stall;
    hz.if_id_write  = ~stall;
    hz.id_ex_bubble = stall;
    hz.if_id_flush  = flush;
  end

  // EX operand forwarding; the younger MEM writer wins over WB.
  always_comb begin
    hz.fw_a_sel = 2'b00;
    hz.fw_b_sel = 2'b00;
    if (match(mem_q.valid, mem_q.rd, mem_q.vec, ex_q.rs1, ex_q.vsrc))
      hz.fw_a_sel = mem_q.load ? 2'b10 : 2'b01;
    else if (match(wb_q.valid, wb_q.rd, wb_q.vec, ex_q.rs1, ex_q.vsrc))
      hz.fw_a_sel = 2'b11;
    if (match(mem_q.valid, mem_q.rd, mem_q.vec, ex_q.rs2, ex_q.vsrc))
      hz.fw_b_sel = mem_q.load ? 2'b10 : 2'b01;
    else if (match(wb_q.valid, wb_q.rd, wb_q.vec, ex_q.rs2, ex_q.vsrc))
      hz.fw_b_sel = 2'b11;
  end

  // Scoreboard shift EX -> MEM -> WB; a stalled ID enters EX as a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q.valid  <= mem_q.valid;
      wb_q.rd     <= mem_q.rd;
      wb_q.vec    <= mem_q.vec;
      mem_q.valid <= ex_q.valid;
      mem_q.rd    <= ex_q.rd;
      mem_q.vec   <= ex_q.vec;
      mem_q.load  <= ex_q.load;
      ex_q.valid  <= (hz.id_reg_write | hz.id_vreg_write) & ~stall;
      ex_q.rd     <= hz.id_rd;
      ex_q.vec    <= hz.id_vreg_write;
      ex_q.load   <= hz.id_is_load;
      ex_q.rs1    <= hz.id_rs1;
      ex_q.rs2    <= hz.id_rs2;
      ex_q.vsrc   <= hz.id_vec_src;
    end
  end

  // Flush FSM state and remaining-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Flush next-state: the first flush cycle is the branch cycle itself, so
  // the FLUSH state only covers the remaining FLUSH_CYCLES-1 cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hz.branch_taken && !stall) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      S_FLUSH: begin
        flush  = 1'b1;
        fcnt_d = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1))
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations (1-cycle flush / 16-bit
// counters and 3-cycle flush / 2-bit counters) share one ID stimulus stream
// and are checked every cycle against an instruction-history model.
module tb_hazard_scoreboard;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(16)) hz0 ();
  hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(2))  hz1 ();

  hazard_scoreboard #(.REG_AW(AW), .FLUSH_CYCLES(1), .ZERO_REG(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .hz(hz0));
  hazard_scoreboard #(.REG_AW(AW), .FLUSH_CYCLES(3), .ZERO_REG(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .hz(hz1));

  typedef struct {
    bit valid; bit rw; bit vw; int rd; bit vec; bit load;
    int rs1; int rs2; bit vsrc; bit br;
  } ins_t;

  // pipe[0] is the instruction in EX, pipe[1] one ahead, pipe[2] two ahead
  ins_t cur;
  ins_t pipe [3];
  int   flush_left [2];
  int   stall_cnt  [2];
  int   flush_cnt  [2];
  int   flush_len  [2] = '{1, 3};
  int   cnt_max    [2] = '{65535, 3};
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input ins_t w, input int rs, input bit vsrc);
    if (!w.valid || w.vec != vsrc || w.rd != rs) return 1'b0;
    if (!vsrc && rs == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int fwd(input int rs, input bit vsrc);
    if (writes(pipe[1], rs, vsrc)) return pipe[1].load ? 2 : 1;
    if (writes(pipe[2], rs, vsrc)) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    for (int c = 0; c < 2; c++) begin
      flush_left[c] = 0; stall_cnt[c] = 0; flush_cnt[c] = 0;
    end
  endtask

  task automatic set_id(input int rs1, input int rs2, input int rd, input bit rw,
                        input bit vw, input bit vsrc, input bit load, input bit br);
    cur = '{valid: rw | vw, rw: rw, vw: vw, rd: rd, vec: vw, load: load,
            rs1: rs1, rs2: rs2, vsrc: vsrc, br: br};
    hz0.id_rs1 = AW'(rs1); hz1.id_rs1 = AW'(rs1);
    hz0.id_rs2 = AW'(rs2); hz1.id_rs2 = AW'(rs2);
    hz0.id_rd  = AW'(rd);  hz1.id_rd  = AW'(rd);
    hz0.id_reg_write  = rw;   hz1.id_reg_write  = rw;
    hz0.id_vreg_write = vw;   hz1.id_vreg_write = vw;
    hz0.id_vec_src    = vsrc; hz1.id_vec_src    = vsrc;
    hz0.id_is_load    = load; hz1.id_is_load    = load;
    hz0.branch_taken  = br;   hz1.branch_taken  = br;
  endtask

  task automatic check_outs(input int c, input logic pcw, input logic ifw,
                            input logic fl, input logic bub, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [15:0] sc,
                            input logic [15:0] fc, input bit st, input bit exp_fl);
    check($sformatf("c%0d_pc_write", c), pcw, !st);
    check($sformatf("c%0d_if_id_write", c), ifw, !st);
    check($sformatf("c%0d_bubble", c), bub, st);
    check($sformatf("c%0d_flush", c), fl, exp_fl);
    check($sformatf("c%0d_fw_a", c), fa, fwd(pipe[0].rs1, pipe[0].vsrc));
    check($sformatf("c%0d_fw_b", c), fb, fwd(pipe[0].rs2, pipe[0].vsrc));
    check($sformatf("c%0d_stall_cnt", c), sc, stall_cnt[c]);
    check($sformatf("c%0d_flush_cnt", c), fc, flush_cnt[c]);
  endtask

  // One pipeline cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(output bit stalled);
    bit st;
    bit fl [2];
    @(negedge clk);
    st = pipe[0].load &&
         (writes(pipe[0], cur.rs1, cur.vsrc) || writes(pipe[0], cur.rs2, cur.vsrc));
    for (int c = 0; c < 2; c++) fl[c] = (flush_left[c] > 0) || (cur.br && !st);
    check_outs(0, hz0.pc_write, hz0.if_id_write, hz0.if_id_flush, hz0.id_ex_bubble,
               hz0.fw_a_sel, hz0.fw_b_sel, hz0.stall_count, hz0.flush_count, st, fl[0]);
    check_outs(1, hz1.pc_write, hz1.if_id_write, hz1.if_id_flush, hz1.id_ex_bubble,
               hz1.fw_a_sel, hz1.fw_b_sel, 16'(hz1.stall_count), 16'(hz1.flush_count),
               st, fl[1]);
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (st && stall_cnt[c] < cnt_max[c]) stall_cnt[c]++;
      if (fl[c] && flush_cnt[c] < cnt_max[c]) flush_cnt[c]++;
      if (flush_left[c] > 0) flush_left[c]--;
      else if (cur.br && !st) flush_left[c] = flush_len[c] - 1;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = cur;
    if (st) pipe[0].valid = 1'b0;
    #1;
    stalled = st;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input bit rw,
                       input bit vw, input bit vsrc, input bit load, input bit br);
    set_id(rs1, rs2, rd, rw, vw, vsrc, load, br);
    step(last_stall);
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pcw0"}, hz0.pc_write, 1'b1);
    check({tag, "_ifw0"}, hz0.if_id_write, 1'b1);
    check({tag, "_flush0"}, hz0.if_id_flush, 1'b0);
    check({tag, "_bub0"}, hz0.id_ex_bubble, 1'b0);
    check({tag, "_fwa0"}, hz0.fw_a_sel, 2'b00);
    check({tag, "_fwb0"}, hz0.fw_b_sel, 2'b00);
    check({tag, "_sc0"}, hz0.stall_count, 16'd0);
    check({tag, "_fc0"}, hz0.flush_count, 16'd0);
    check({tag, "_pcw1"}, hz1.pc_write, 1'b1);
    check({tag, "_flush1"}, hz1.if_id_flush, 1'b0);
    check({tag, "_bub1"}, hz1.id_ex_bubble, 1'b0);
    check({tag, "_fwa1"}, hz1.fw_a_sel, 2'b00);
    check({tag, "_sc1"}, hz1.stall_count, 2'd0);
    check({tag, "_fc1"}, hz1.flush_count, 2'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // ADD r3 ; ADD r4,r3,r3 -> MEM forward on both operands
    issue(1, 2, 3, 1, 0, 0, 0, 0);
    issue(3, 3, 4, 1, 0, 0, 0, 0);
    nop(); nop();
    // LOAD r5 ; ADD r6,r5,r1 -> one stall, then MemData forward
    issue(1, 0, 5, 1, 0, 0, 1, 0);
    issue(5, 1, 6, 1, 0, 0, 0, 0);
    issue(5, 1, 6, 1, 0, 0, 0, 0);
    nop(); nop();
    // write r2, two unrelated, read r2 -> no forward
    issue(0, 0, 2, 1, 0, 0, 0, 0);
    issue(1, 1, 9, 1, 0, 0, 0, 0);
    issue(1, 1, 10, 1, 0, 0, 0, 0);
    issue(2, 2, 7, 1, 0, 0, 0, 0);
    nop();
    // write r2, one gap, read r2 -> WB forward
    issue(0, 0, 2, 1, 0, 0, 0, 0);
    nop();
    issue(2, 0, 7, 1, 0, 0, 0, 0);
    nop();
    // vector write v3 then scalar read r3; scalar write r0 then read r0
    issue(0, 0, 3, 0, 1, 0, 1, 0);
    issue(3, 3, 8, 1, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 0, 0, 1, 0);
    issue(0, 0, 9, 1, 0, 0, 0, 0);
    nop();
    // branch, then a second branch inside the 3-cycle window
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    nop(); nop(); nop();
    // five dependent loads saturate the 2-bit stall counter
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 5, 1, 0, 0, 1, 0);
      issue(0, 5, 6, 1, 0, 0, 0, 1);
      issue(0, 5, 6, 1, 0, 0, 0, 1);
    end
    nop(); nop(); nop();

    // reset in the middle of a 3-cycle flush
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    rst = 1'b0;
    #2;
    check_reset_outputs("midflush");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    last_stall = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (last_stall) step(last_stall);
      else issue(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                 ($urandom_range(1) == 1), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(9) < 3), ($urandom_range(9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
